// File: rtl/operand_stream_ctrl.sv
// operand_stream_ctrl: arbitrates one single-port operand bank between a host
// loader (idle only) and a streaming reader that walks an N x N matrix in
// row-major or transposed order over a valid/ready output.
// Optional feature macro: OPSTREAM_PERF_EN (adds stall_cnt_o stall counter).
module operand_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned DIM_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  host_wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wr_data_i,
  output logic                  host_wr_ready_o,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  dim_i,
  input  logic                  transpose_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] mat_addr_o,
  output logic                  mat_wr_en_o,
  output logic [DATA_WIDTH-1:0] mat_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mat_rd_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef OPSTREAM_PERF_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DIM_WIDTH-1:0]  n_q;
  logic [DIM_WIDTH-1:0]  row_q;
  logic [DIM_WIDTH-1:0]  col_q;
  logic                  transpose_q;
  logic [ADDR_WIDTH-1:0] held_addr_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  done_q;
  logic                  err_q;

  logic                  issue_fire;
  logic                  dim_ok;
  logic                  col_wrap;
  logic                  is_last;
  logic [ADDR_WIDTH-1:0] issue_addr;

  // Issue decision, walk position decode and bank address of the next element
  always_comb begin
    issue_fire = (state_q == STREAM) && (!out_valid_q || out_ready_i);
    dim_ok     = (dim_i != '0) && (dim_i <= DIM_WIDTH'(MAX_DIM));
    col_wrap   = (col_q == (n_q - DIM_WIDTH'(1)));
    is_last    = col_wrap && (row_q == (n_q - DIM_WIDTH'(1)));
    // Transposed walk swaps the roles of the loop indices in the address
    if (transpose_q) begin
      issue_addr = ADDR_WIDTH'(col_q * MAX_DIM + row_q);
    end else begin
      issue_addr = ADDR_WIDTH'(row_q * MAX_DIM + col_q);
    end
  end

  // Shared bank port mux: host owns it in IDLE, streamer otherwise
  always_comb begin
    host_wr_ready_o = 1'b0;
    mat_wr_en_o     = 1'b0;
    mat_wr_data_o   = host_wr_data_i;
    mat_addr_o      = held_addr_q;
    if (state_q == IDLE) begin
      host_wr_ready_o = 1'b1;
      mat_wr_en_o     = host_wr_valid_i;
      mat_addr_o      = host_wr_addr_i;
    end else if (issue_fire) begin
      mat_addr_o = issue_addr;
    end
  end

  // Sequencer FSM with registered stream handshake and status pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      transpose_q <= 1'b0;
      held_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_i && (state_q != IDLE)) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (dim_ok) begin
                n_q         <= dim_i;
                transpose_q <= transpose_i;
                row_q       <= '0;
                col_q       <= '0;
                state_q     <= STREAM;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (issue_fire) begin
              out_valid_q <= 1'b1;
              out_last_q  <= is_last;
              held_addr_q <= issue_addr;
              if (col_wrap) begin
                col_q <= '0;
                row_q <= row_q + DIM_WIDTH'(1);
              end else begin
                col_q <= col_q + DIM_WIDTH'(1);
              end
              if (is_last) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (out_ready_i) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef OPSTREAM_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled output cycles in the current stream
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && start_i && dim_ok) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = mat_rd_data_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_operand_stream_ctrl.sv
// Directed bench for operand_stream_ctrl with a registered-read bank model.
module tb_operand_stream_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned DIMW = 3;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            host_wr_valid_i;
  logic [AW-1:0]   host_wr_addr_i;
  logic [DW-1:0]   host_wr_data_i;
  logic            host_wr_ready_o;
  logic            start_i;
  logic [DIMW-1:0] dim_i;
  logic            transpose_i;
  logic            abort_i;
  logic [AW-1:0]   mat_addr_o;
  logic            mat_wr_en_o;
  logic [DW-1:0]   mat_wr_data_o;
  logic [DW-1:0]   mat_rd_data_i;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic            out_last_o;
  logic            out_ready_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
`ifdef OPSTREAM_PERF_EN
  logic [15:0]     stall_cnt_o;
`endif

  always #5 clk = ~clk;

  operand_stream_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .host_wr_valid_i (host_wr_valid_i),
    .host_wr_addr_i  (host_wr_addr_i),
    .host_wr_data_i  (host_wr_data_i),
    .host_wr_ready_o (host_wr_ready_o),
    .start_i         (start_i),
    .dim_i           (dim_i),
    .transpose_i     (transpose_i),
    .abort_i         (abort_i),
    .mat_addr_o      (mat_addr_o),
    .mat_wr_en_o     (mat_wr_en_o),
    .mat_wr_data_o   (mat_wr_data_o),
    .mat_rd_data_i   (mat_rd_data_i),
    .out_valid_o     (out_valid_o),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
`ifdef OPSTREAM_PERF_EN
    ,
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  // Single-port bank: write and registered read at the same edge
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mat_wr_en_o) mem[mat_addr_o] <= mat_wr_data_o;
    mat_rd_data_i <= mem[mat_addr_o];
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input int dim, input bit tr);
    start_i     = 1'b1;
    dim_i       = DIMW'(dim);
    transpose_i = tr;
    step();
    start_i     = 1'b0;
  endtask

  int got_data[$];
  bit got_last[$];
  int done_cyc, first_cyc, stall_cyc, last_acc_cyc;

  // Drains the stream; toggle applies ready pattern 1,0,0,1; abort_at>0 aborts on that element
  task automatic collect(input bit toggle, input int abort_at);
    logic [31:0] hold;
    bit          hold_pend;
    bit          fin;
    int          cyc;
    hold_pend = 1'b0;
    fin       = 1'b0;
    cyc       = 0;
    hold      = '0;
    got_data.delete();
    got_last.delete();
    done_cyc = -1; first_cyc = -1; stall_cyc = 0; last_acc_cyc = -1;
    while (!fin && cyc < 200) begin
      if (hold_pend) begin
        check("stall_hold", out_data_o, hold);
        hold_pend = 1'b0;
      end
      if (out_valid_o && first_cyc < 0) first_cyc = cyc;
      if (done_o) begin
        done_cyc = cyc;
        fin      = 1'b1;
      end else if (abort_at > 0 && out_valid_o && got_data.size() == abort_at - 1) begin
        abort_i     = 1'b1;
        out_ready_i = 1'b0;
        step();
        fin = 1'b1;
      end else begin
        out_ready_i = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        if (out_valid_o && out_ready_i) begin
          got_data.push_back(int'(out_data_o));
          got_last.push_back(out_last_o);
          last_acc_cyc = cyc;
        end else if (out_valid_o) begin
          stall_cyc++;
          hold      = out_data_o;
          hold_pend = 1'b1;
        end
        step();
        cyc++;
      end
    end
    abort_i     = 1'b0;
    out_ready_i = 1'b1;
    if (!fin) check("collect_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string tag, input int exp_addr[$]);
    check({tag, "_count"}, got_data.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[i], 100 + exp_addr[i]);
      check({tag, "_last"}, 32'(got_last[i]), 32'(i == exp_addr.size() - 1));
    end
  endtask

  int exp_q[$];

  initial begin
    rst_ni = 1'b0; host_wr_valid_i = 1'b0; host_wr_addr_i = '0; host_wr_data_i = '0;
    start_i = 1'b0; dim_i = '0; transpose_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    check("rst_valid", out_valid_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_hready", host_wr_ready_o, 1);
    rst_ni = 1'b1;
    step();

    // Load bank with 100+k
    for (int k = 0; k < 16; k++) begin
      host_wr_valid_i = 1'b1;
      host_wr_addr_i  = AW'(k);
      host_wr_data_i  = DW'(100 + k);
      check("load_ready", host_wr_ready_o, 1);
      step();
    end
    host_wr_valid_i = 1'b0;
    check("load_mem5", mem[5], 105);

    // N=4 row-major, full throughput
    start_stream(4, 1'b0);
    check("t1_busy", busy_o, 1);
    check("t1_valid_early", out_valid_o, 0);
    collect(1'b0, 0);
    check("t1_latency", first_cyc, 1);
    exp_q = {0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
    check_seq("t1", exp_q);
    check("t1_done_cyc", done_cyc, 17);
    step();
    check("t1_done_pulse", done_o, 0);
    check("t1_busy_after", busy_o, 0);

    // N=3 transposed
    start_stream(3, 1'b1);
    collect(1'b0, 0);
    exp_q = {0,4,8,1,5,9,2,6,10};
    check_seq("t2", exp_q);
    check("t2_done_cyc", done_cyc, 10);
    step();

    // N=4 with ready pattern 1,0,0,1
    start_stream(4, 1'b0);
    collect(1'b1, 0);
    exp_q = {0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
    check_seq("t3", exp_q);
    check("t3_done_after_last", done_cyc, last_acc_cyc + 1);
`ifdef OPSTREAM_PERF_EN
    check("t3_stall_cnt", stall_cnt_o, stall_cyc);
`endif
    step();

    // Invalid dimensions
    start_stream(0, 1'b0);
    check("err_dim0", err_o, 1);
    check("err_dim0_busy", busy_o, 0);
    step();
    check("err_dim0_clear", err_o, 0);
    start_stream(5, 1'b0);
    check("err_dim5", err_o, 1);
    check("err_dim5_busy", busy_o, 0);
    step();

    // Host write and bad start during a stalled stream
    start_stream(4, 1'b0);
    out_ready_i     = 1'b0;
    host_wr_valid_i = 1'b1;
    host_wr_addr_i  = AW'(5);
    host_wr_data_i  = DW'(999);
    check("busy_hready", host_wr_ready_o, 0);
    check("busy_wren", mat_wr_en_o, 0);
    step();
    start_i = 1'b1; dim_i = '0;
    step();
    start_i = 1'b0;
    check("busy_start_noerr", err_o, 0);
    check("busy_start_busy", busy_o, 1);
    host_wr_valid_i = 1'b0;
    out_ready_i     = 1'b1;
    collect(1'b0, 0);
    exp_q = {0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
    check_seq("t5", exp_q);
    check("t5_mem5", mem[5], 105);
    step();

    // Abort on third element, then N=2
    start_stream(4, 1'b0);
    collect(1'b0, 3);
    check("abort_valid", out_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_count", got_data.size(), 2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", done_o, 0);
    end
    start_stream(2, 1'b0);
    collect(1'b0, 0);
    exp_q = {0,1,4,5};
    check_seq("t6", exp_q);
    step();

    // Reset mid-stream
    start_stream(4, 1'b0);
    step(); step(); step();
    check("pre_rst_valid", out_valid_o, 1);
    rst_ni = 1'b0;
    step();
    check("mrst_valid", out_valid_o, 0);
    check("mrst_last", out_last_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_err", err_o, 0);
    rst_ni          = 1'b1;
    host_wr_valid_i = 1'b1;
    host_wr_addr_i  = AW'(15);
    host_wr_data_i  = DW'(777);
    check("mrst_hready", host_wr_ready_o, 1);
    step();
    host_wr_valid_i = 1'b0;
    check("mrst_mem15", mem[15], 777);
    check("mrst_no_done", done_o, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
